// File: rtl/cyc_lock_pkg.sv
// Shared types and widths for the cyclic-lock key load controller.
package cyc_lock_pkg;

    localparam int CNT_W     = 8;
    localparam int DEF_KEY_W = 2;
    localparam int DEF_PAT_W = 5;
    localparam int DEF_RSP_W = 2;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        APPLY   = 3'd2,
        SETTLE  = 3'd3,
        COMPARE = 3'd4,
        DONE    = 3'd5,
        FAIL    = 3'd6
    } state_t;

    // Increment that holds at lim instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic [CNT_W-1:0] lim);
        logic [CNT_W-1:0] r;
        if (v < lim) begin
            r = v + 8'd1;
        end else begin
            r = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/cyc_settle_timer.sv
// Loadable down-counter that times how long the locked core's feedback loops get to settle.
module cyc_settle_timer
    import cyc_lock_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_value,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_cnt;

    // Load has priority; decrement stops at zero.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_value;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 8'd1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/cyc_key_load_ctrl.sv
// Key load / check sequencer for a cyclically-locked core.
// Optional KEY_ZEROIZE_EN: a failed check clears the key and locks out key_start until reset.
module cyc_key_load_ctrl
    import cyc_lock_pkg::*;
#(
    parameter int KEY_W      = DEF_KEY_W,
    parameter int PAT_W      = DEF_PAT_W,
    parameter int RSP_W      = DEF_RSP_W,
    parameter int NUM_VEC    = 4,
    parameter int SETTLE_CYC = 3
) (
    input  logic             CK,
    input  logic             RST,
    input  logic             key_start,
    input  logic             key_valid,
    input  logic             key_bit,
    output logic             key_ready,
    input  logic             chk_valid,
    input  logic [PAT_W-1:0] chk_pattern,
    input  logic [RSP_W-1:0] chk_expect,
    output logic             chk_ready,
    output logic [KEY_W-1:0] keyinput,
    output logic [PAT_W-1:0] core_in,
    input  logic [RSP_W-1:0] core_out,
    output logic             busy,
    output logic             unlocked,
    output logic             fail
);

    localparam logic [CNT_W-1:0] L_KEY_N     = CNT_W'(KEY_W);
    localparam logic [CNT_W-1:0] L_VEC_LAST  = CNT_W'(NUM_VEC - 1);
    localparam logic [CNT_W-1:0] L_SETTLE_LD = CNT_W'(SETTLE_CYC - 1);

    state_t           r_state;
    logic [KEY_W-1:0] r_stage;
    logic [KEY_W-1:0] r_key;
    logic [PAT_W-1:0] r_core_in;
    logic [RSP_W-1:0] r_exp;
    logic [RSP_W-1:0] r_rsp;
    logic [CNT_W-1:0] r_bit_cnt;
    logic [CNT_W-1:0] r_vec_cnt;
    logic             r_key_ready;
    logic             r_chk_ready;
    logic             r_busy;
    logic             r_unlocked;
    logic             r_fail;
`ifdef KEY_ZEROIZE_EN
    logic             r_fail_lock;
`endif

    logic w_start_ok;
    logic w_timer_load;
    logic w_timer_dec;
    logic w_timer_zero;

`ifdef KEY_ZEROIZE_EN
    assign w_start_ok = key_start && !r_fail_lock;
`else
    assign w_start_ok = key_start;
`endif

    assign w_timer_load = (r_state == APPLY) && r_chk_ready && chk_valid;
    assign w_timer_dec  = (r_state == SETTLE);

    cyc_settle_timer u_settle_timer (
        .i_clk   (CK),
        .i_rst   (RST),
        .i_load  (w_timer_load),
        .i_value (L_SETTLE_LD),
        .i_dec   (w_timer_dec),
        .o_zero  (w_timer_zero)
    );

    // Sequencer FSM with its datapath and registered handshake/status flags.
    always_ff @(posedge CK) begin
        if (RST) begin
            r_state     <= IDLE;
            r_stage     <= '0;
            r_key       <= '0;
            r_core_in   <= '0;
            r_exp       <= '0;
            r_rsp       <= '0;
            r_bit_cnt   <= '0;
            r_vec_cnt   <= '0;
            r_key_ready <= 1'b0;
            r_chk_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_unlocked  <= 1'b0;
            r_fail      <= 1'b0;
`ifdef KEY_ZEROIZE_EN
            r_fail_lock <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE, DONE, FAIL: begin
                    if (w_start_ok) begin
                        r_state     <= LOAD;
                        r_bit_cnt   <= '0;
                        r_key_ready <= 1'b1;
                        r_busy      <= 1'b1;
                        r_unlocked  <= 1'b0;
                        r_fail      <= 1'b0;
                    end
                end
                LOAD: begin
                    // Staging fills completely before the key bus moves, so the core never sees a partial key.
                    if (r_bit_cnt == L_KEY_N) begin
                        r_key       <= r_stage;
                        r_vec_cnt   <= '0;
                        r_chk_ready <= 1'b1;
                        r_state     <= APPLY;
                    end else if (r_key_ready && key_valid) begin
                        r_stage   <= (r_stage << 1) | KEY_W'(key_bit);
                        r_bit_cnt <= sat_inc(r_bit_cnt, L_KEY_N);
                        if (r_bit_cnt == (L_KEY_N - 8'd1)) begin
                            r_key_ready <= 1'b0;
                        end
                    end
                end
                APPLY: begin
                    if (r_chk_ready && chk_valid) begin
                        r_core_in   <= chk_pattern;
                        r_exp       <= chk_expect;
                        r_chk_ready <= 1'b0;
                        r_state     <= SETTLE;
                    end
                end
                SETTLE: begin
                    // Response captured exactly SETTLE_CYC edges after core_in changed.
                    if (w_timer_zero) begin
                        r_rsp   <= core_out;
                        r_state <= COMPARE;
                    end
                end
                COMPARE: begin
                    if (r_rsp != r_exp) begin
                        r_state <= FAIL;
                        r_fail  <= 1'b1;
                        r_busy  <= 1'b0;
`ifdef KEY_ZEROIZE_EN
                        r_key       <= '0;
                        r_fail_lock <= 1'b1;
`endif
                    end else if (r_vec_cnt == L_VEC_LAST) begin
                        r_state    <= DONE;
                        r_unlocked <= 1'b1;
                        r_busy     <= 1'b0;
                    end else begin
                        r_vec_cnt   <= sat_inc(r_vec_cnt, L_VEC_LAST);
                        r_chk_ready <= 1'b1;
                        r_state     <= APPLY;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_key_ready <= 1'b0;
                    r_chk_ready <= 1'b0;
                    r_busy      <= 1'b0;
                    r_unlocked  <= 1'b0;
                    r_fail      <= 1'b0;
                end
            endcase
        end
    end

    assign key_ready = r_key_ready;
    assign chk_ready = r_chk_ready;
    assign keyinput  = r_key;
    assign core_in   = r_core_in;
    assign busy      = r_busy;
    assign unlocked  = r_unlocked;
    assign fail      = r_fail;

endmodule
